// File: rtl/rshift_if.sv
// Operand/result bundle for the sequential right shifter; the control side
// drives operands and start (master), the shifter drives results and status (slave).
interface rshift_if #(
   parameter int WIDTH  = 4,
   parameter int DIST_W = 4
);
   logic              start;
   logic              arith;
   logic [DIST_W-1:0] distance;
   logic [WIDTH-1:0]  in;
   logic [WIDTH-1:0]  out;
   logic              carry;
   logic              busy;
   logic              done;

   modport master (
      output start, arith, distance, in,
      input  out, carry, busy, done
   );

   modport slave (
      input  start, arith, distance, in,
      output out, carry, busy, done
   );
endinterface

// File: rtl/rshift.sv
// Sequential right shifter (SHR/SAR), one bit per clock; done pulses min(distance,WIDTH)+1
// cycles after start; start is ignored while busy, and out/carry change only on completion.
module rshift #(
   parameter int WIDTH  = 4,
   parameter int DIST_W = 4
) (
   input  logic     clock,
   input  logic     reset_n,
   rshift_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               arith_q, arith_d;
   logic               sign_q, sign_d;
   logic               cin_q, cin_d;
   logic               carry_q, carry_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [CNT_W-1:0]   n_eff;
   logic [WIDTH-1:0]   shifted;

   // Any distance at or beyond the operand width saturates to WIDTH.
   always_comb begin
      n_eff = CNT_W'(WIDTH);
      if (32'(bus.distance) < 32'(WIDTH)) begin
         n_eff = CNT_W'(bus.distance);
      end
   end

   assign shifted = {arith_q & sign_q, work_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      arith_d = arith_q;
      sign_d  = sign_q;
      cin_d   = cin_q;
      carry_d = carry_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               work_d  = bus.in;
               arith_d = bus.arith;
               sign_d  = bus.in[WIDTH-1];
               cnt_d   = n_eff;
               cin_d   = 1'b0;
               if (n_eff == '0) begin
                  state_d = DONE;
                  out_d   = bus.in;
                  carry_d = 1'b0;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_d = shifted;
            cin_d  = work_q[0];
            cnt_d  = cnt_q - CNT_W'(1);
            // Results are published on the same edge as the final shift.
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               out_d   = shifted;
               carry_d = cin_d;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         arith_q <= 1'b0;
         sign_q  <= 1'b0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         arith_q <= arith_d;
         sign_q  <= sign_d;
         cin_q   <= cin_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.carry = carry_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_rshift.sv
// Bench for rshift: directed scenarios plus randomized operations against an
// arithmetic reference model.
module tb_rshift;
   localparam int W  = 4;
   localparam int DW = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   rshift_if #(.WIDTH(W), .DIST_W(DW)) bus ();

   rshift #(.WIDTH(W), .DIST_W(DW)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed/unsigned integer shift with saturation at W.
   function automatic void model(input logic [W-1:0] i, input int d, input bit a,
                                 output logic [W-1:0] o, output logic c);
      int n;
      int v;
      int sv;
      int r;
      n  = (d > W) ? W : d;
      v  = int'(i);
      sv = (a && i[W-1]) ? v - (1 << W) : v;
      r  = sv >>> n;
      o  = r[W-1:0];
      c  = (n == 0) ? 1'b0 : 1'(((v >> (n - 1)) & 1));
   endfunction

   // Launches one op and watches it to completion, scrambling inputs after acceptance.
   task automatic run_op(input logic [W-1:0] i, input int d, input bit a,
                         output logic [W-1:0] o, output logic c,
                         output int nbusy, output int didx, output int dw, output int early);
      logic [W-1:0] o0;
      logic         c0;
      @(negedge clk);
      bus.in = i; bus.distance = DW'(d); bus.arith = a; bus.start = 1'b1;
      o0 = bus.out; c0 = bus.carry;
      @(negedge clk);
      bus.start = 1'b0;
      bus.in = W'($urandom); bus.distance = DW'($urandom); bus.arith = 1'($urandom);
      o = 'x; c = 1'bx; nbusy = 0; didx = -1; dw = 0; early = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.busy) nbusy++;
         if (bus.done) begin
            if (didx < 0) begin
               didx = k; o = bus.out; c = bus.carry;
            end
            dw++;
         end else if (didx < 0 && (bus.out !== o0 || bus.carry !== c0)) begin
            early++;
         end
         if (didx >= 0 && !bus.done) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b1; bus.in = 4'b1111; bus.distance = 4'd1; bus.arith = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (bus.out !== 4'b0000) begin bad++; $display("FAIL reset_out got=%b want=0000", bus.out); end
      total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", bus.carry); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      rst_n = 1'b1; bus.start = 1'b0;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL post_reset_idle got busy=%b done=%b want 0/0", bus.busy, bus.done);
      end
   endtask

   // Directed op: compares result, busy length, done latency and pulse width.
   task automatic test_case(input string name, input logic [W-1:0] i, input int d, input bit a,
                            input logic [W-1:0] exp_o, input logic exp_c);
      logic [W-1:0] o;
      logic c;
      int nb, di, dw, early, n;
      n = (d > W) ? W : d;
      run_op(i, d, a, o, c, nb, di, dw, early);
      total++; if (o !== exp_o) begin bad++; $display("FAIL %s_out got=%b want=%b", name, o, exp_o); end
      total++; if (c !== exp_c) begin bad++; $display("FAIL %s_carry got=%b want=%b", name, c, exp_c); end
      total++; if (nb !== n) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, nb, n); end
      total++; if (di !== n) begin bad++; $display("FAIL %s_done_latency got=%0d want=%0d", name, di, n); end
      total++; if (dw !== 1) begin bad++; $display("FAIL %s_done_width got=%0d want=1", name, dw); end
      total++; if (early !== 0) begin bad++; $display("FAIL %s_out_early got=%0d want=0", name, early); end
   endtask

   task automatic test_ignore_start_busy;
      int ndone;
      @(negedge clk);
      bus.in = 4'b1000; bus.distance = 4'd2; bus.arith = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.in = 4'b1111; bus.distance = 4'd3;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ign_busy0 got=%b want=1", bus.busy); end
      @(negedge clk);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ign_busy1 got=%b want=1", bus.busy); end
      @(negedge clk);
      bus.start = 1'b0;
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b want=1", bus.done); end
      total++; if (bus.out !== 4'b0010) begin bad++; $display("FAIL ign_out got=%b want=0010", bus.out); end
      total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL ign_carry got=%b want=0", bus.carry); end
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) ndone++;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL ign_extra_activity got=%0d want=0", ndone); end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] eo;
      logic ec;
      int k, nb, di;
      model(4'b0110, 2, 1'b1, eo, ec);
      @(negedge clk);
      bus.in = 4'b1011; bus.distance = 4'd1; bus.arith = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 20) begin @(negedge clk); k++; end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b want=1", bus.done); end
      bus.in = 4'b0110; bus.distance = 4'd2; bus.arith = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.in = 4'b0000;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble got busy=%b want=1", bus.busy); end
      nb = 0; di = -1;
      for (int j = 0; j < 20; j++) begin
         if (bus.busy) nb++;
         if (bus.done) begin di = j; break; end
         @(negedge clk);
      end
      total++; if (di !== 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", di); end
      total++; if (nb !== 2) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=2", nb); end
      total++; if (bus.out !== eo) begin bad++; $display("FAIL b2b_out got=%b want=%b", bus.out, eo); end
      total++; if (bus.carry !== ec) begin bad++; $display("FAIL b2b_carry got=%b want=%b", bus.carry, ec); end
   endtask

   task automatic test_reset_mid;
      int ndone;
      @(negedge clk);
      bus.in = 4'b1100; bus.distance = 4'd4; bus.arith = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b want=1", bus.busy); end
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (bus.out !== 4'b0000 || bus.carry !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL rmid_outputs got out=%b carry=%b busy=%b done=%b want all 0",
                         bus.out, bus.carry, bus.busy, bus.done);
      end
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", ndone); end
      test_case("rmid_next", 4'b1100, 4, 1'b1, 4'b1111, 1'b1);
   endtask

   task automatic test_random;
      logic [W-1:0] i, o, eo;
      logic c, ec;
      int d, nb, di, dw, early, n;
      bit a;
      for (int t = 0; t < 1000; t++) begin
         i = W'($urandom);
         d = int'($urandom_range(0, (1 << DW) - 1));
         a = 1'($urandom);
         n = (d > W) ? W : d;
         model(i, d, a, eo, ec);
         run_op(i, d, a, o, c, nb, di, dw, early);
         total++; if (o !== eo) begin bad++; $display("FAIL rnd%0d_out in=%b d=%0d a=%0d got=%b want=%b", t, i, d, a, o, eo); end
         total++; if (c !== ec) begin bad++; $display("FAIL rnd%0d_carry in=%b d=%0d a=%0d got=%b want=%b", t, i, d, a, c, ec); end
         total++; if (nb !== n || di !== n) begin bad++; $display("FAIL rnd%0d_timing busy=%0d done_at=%0d want=%0d", t, nb, di, n); end
         total++; if (dw !== 1) begin bad++; $display("FAIL rnd%0d_done_width got=%0d want=1", t, dw); end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.arith = 1'b0; bus.distance = '0; bus.in = '0;
      test_reset();
      test_case("logical_d1", 4'b1011, 1, 1'b0, 4'b0101, 1'b1);
      test_case("arith_d2",   4'b1011, 2, 1'b1, 4'b1110, 1'b1);
      test_case("zero_dist",  4'b0110, 0, 1'b0, 4'b0110, 1'b0);
      test_case("sat_arith",  4'b1001, 9, 1'b1, 4'b1111, 1'b1);
      test_case("sat_logic",  4'b1001, 9, 1'b0, 4'b0000, 1'b1);
      test_case("exact_w",    4'b0111, 4, 1'b1, 4'b0000, 1'b0);
      test_ignore_start_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
